// File: rtl/led_pkg.sv
// Shared types for the front-panel LED event arbiter.
package led_pkg;

  localparam int LED_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE_S,
    ARB_SHOW_S,
    ARB_GAP_S
  } arb_state_t;

  typedef logic [LED_W-1:0] led_vec_t;

endpackage

// File: rtl/led_prio_enc.sv
// Combinational priority encoder: the lowest set bit of mask wins.
module led_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_event_arbiter.sv
// Shares the front-panel LEDs between prioritised event requesters; each event
// shows its pattern for HOLD_TICKS sample ticks followed by a GAP_TICKS dark gap.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ARB_IDLE_S | no event active; base_leds_i passes through, grants any pending
//   ARB_SHOW_S | cur_pat displayed; higher-priority pending events preempt
//   ARB_GAP_S  | LEDs dark between events; no preemption
module led_event_arbiter
  import led_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 4800,
  parameter int GAP_TICKS  = 480,
  parameter int CNT_W      = $clog2(HOLD_TICKS + 1)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   sample_tick_i,
  input  logic [LED_W-1:0]       base_leds_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [LED_W*N_REQ-1:0] pattern_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic                   busy_o,
  output logic [LED_W-1:0]       leds_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  arb_state_t         state_q;
  logic [N_REQ-1:0]   pending_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   cur_idx_q;
  led_vec_t           cur_pat_q;

  logic [N_REQ-1:0]   below_mask;
  logic [N_REQ-1:0]   enc_mask;
  logic [N_REQ-1:0]   enc_onehot;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic [N_REQ-1:0]   pending_nxt;
  led_vec_t           sel_pat;

  // Only requesters strictly above the current one in priority may preempt.
  always_comb begin
    below_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      below_mask[i] = (i < int'(cur_idx_q));
    end
  end

  always_comb begin
    case (state_q)
      ARB_IDLE_S: enc_mask = pending_q;
      ARB_SHOW_S: enc_mask = pending_q & below_mask;
      default:    enc_mask = '0;
    endcase
  end

  led_prio_enc #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .mask   (enc_mask),
    .onehot (enc_onehot),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  // A request arriving in its own grant cycle is absorbed rather than re-queued.
  assign pending_nxt = (pending_q | req_i) & ~enc_onehot;

  always_comb begin
    sel_pat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (enc_onehot[i]) begin
        sel_pat = pattern_i[LED_W*i +: LED_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= ARB_IDLE_S;
      pending_q <= '0;
      cnt_q     <= '0;
      cur_idx_q <= '0;
      cur_pat_q <= '0;
      ack_o     <= '0;
      busy_o    <= 1'b0;
      leds_o    <= '0;
    end else begin
      pending_q <= pending_nxt;
      ack_o     <= '0;
      if (enc_any) begin
        // Fresh grant from IDLE, or preemption in SHOW (wins over hold expiry).
        state_q   <= ARB_SHOW_S;
        cur_idx_q <= enc_idx;
        cur_pat_q <= sel_pat;
        cnt_q     <= HOLD_C;
        ack_o     <= enc_onehot;
        leds_o    <= sel_pat;
        busy_o    <= 1'b1;
      end else begin
        case (state_q)
          ARB_IDLE_S: begin
            leds_o <= base_leds_i;
            busy_o <= 1'b0;
          end
          ARB_SHOW_S: begin
            busy_o <= 1'b1;
            if (sample_tick_i && cnt_q == ONE_C) begin
              state_q <= ARB_GAP_S;
              cnt_q   <= GAP_C;
              leds_o  <= '0;
            end else begin
              if (sample_tick_i) begin
                cnt_q <= cnt_q - ONE_C;
              end
              leds_o <= cur_pat_q;
            end
          end
          ARB_GAP_S: begin
            if (sample_tick_i && cnt_q == ONE_C) begin
              state_q <= ARB_IDLE_S;
              cnt_q   <= '0;
              leds_o  <= base_leds_i;
              busy_o  <= 1'b0;
            end else begin
              if (sample_tick_i) begin
                cnt_q <= cnt_q - ONE_C;
              end
              leds_o <= '0;
              busy_o <= 1'b1;
            end
          end
          default: begin
            state_q <= ARB_IDLE_S;
            cnt_q   <= '0;
            leds_o  <= '0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_event_arbiter.sv
// Scenario bench for led_event_arbiter with N_REQ=4, HOLD_TICKS=3, GAP_TICKS=2.
module tb_led_event_arbiter;

  localparam int N_REQ = 4;

  logic                 clk_i;
  logic                 srst_i;
  logic                 sample_tick_i;
  logic [3:0]           base_leds_i;
  logic [N_REQ-1:0]     req_i;
  logic [4*N_REQ-1:0]   pattern_i;
  logic [N_REQ-1:0]     ack_o;
  logic                 busy_o;
  logic [3:0]           leds_o;

  led_event_arbiter #(
    .N_REQ      (N_REQ),
    .HOLD_TICKS (3),
    .GAP_TICKS  (2)
  ) dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .sample_tick_i (sample_tick_i),
    .base_leds_i   (base_leds_i),
    .req_i         (req_i),
    .pattern_i     (pattern_i),
    .ack_o         (ack_o),
    .busy_o        (busy_o),
    .leds_o        (leds_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       srst;
    logic       tick;
    logic [3:0] req;
    logic [3:0] leds;
    logic [3:0] ack;
    logic       busy;
  } step_t;

  typedef struct {
    logic [3:0] leds;
    logic [3:0] ack;
    logic       busy;
  } exp_t;

  step_t plan_q[$];
  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  localparam logic [3:0] BASE = 4'hA;
  logic [3:0] pat [N_REQ];

  task automatic add(input logic rst, input logic tk, input logic [3:0] rq,
                     input logic [3:0] ld, input logic [3:0] ak, input logic bz,
                     input int n);
    step_t s;
    s.srst = rst; s.tick = tk; s.req = rq; s.leds = ld; s.ack = ak; s.busy = bz;
    repeat (n) plan_q.push_back(s);
  endtask

  // Applies the next planned input cycle, queues its expected outputs, and clocks it.
  task automatic drive_next();
    step_t s;
    exp_t  e;
    s = plan_q.pop_front();
    srst_i        = s.srst;
    sample_tick_i = s.tick;
    req_i         = s.req;
    e.leds = s.leds; e.ack = s.ack; e.busy = s.busy;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   k = 0;
    add(1, 1, 4'b0000, 4'h0, 4'b0000, 0, 2);
    add(0, 1, 4'b0000, BASE, 4'b0000, 0, 2);
    while (plan_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_vec++; if (leds_o !== e.leds) begin n_err++; $display("FAIL reset step %0d: leds_o=%h expected %h", k, leds_o, e.leds); end
      n_vec++; if (ack_o !== e.ack) begin n_err++; $display("FAIL reset step %0d: ack_o=%b expected %b", k, ack_o, e.ack); end
      n_vec++; if (busy_o !== e.busy) begin n_err++; $display("FAIL reset step %0d: busy_o=%b expected %b", k, busy_o, e.busy); end
      k++;
    end
  endtask

  task automatic test_single_event();
    exp_t e;
    int   k = 0;
    add(0, 1, 4'b0100, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, pat[2], 4'b0100, 1, 1);
    add(0, 1, 4'b0000, pat[2], 4'b0000, 1, 2);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 2);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 2);
    while (plan_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_vec++; if (leds_o !== e.leds) begin n_err++; $display("FAIL single step %0d: leds_o=%h expected %h", k, leds_o, e.leds); end
      n_vec++; if (ack_o !== e.ack) begin n_err++; $display("FAIL single step %0d: ack_o=%b expected %b", k, ack_o, e.ack); end
      n_vec++; if (busy_o !== e.busy) begin n_err++; $display("FAIL single step %0d: busy_o=%b expected %b", k, busy_o, e.busy); end
      k++;
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    int   k = 0;
    // Requester 1 arrives mid-hold of requester 3.
    add(0, 1, 4'b1000, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, pat[3], 4'b1000, 1, 1);
    add(0, 1, 4'b0010, pat[3], 4'b0000, 1, 1);
    add(0, 1, 4'b0000, pat[1], 4'b0010, 1, 1);
    add(0, 1, 4'b0000, pat[1], 4'b0000, 1, 2);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 2);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 1);
    // Requester 1 pending on the very tick that ends requester 3's hold.
    add(0, 1, 4'b1000, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, pat[3], 4'b1000, 1, 1);
    add(0, 1, 4'b0000, pat[3], 4'b0000, 1, 1);
    add(0, 1, 4'b0010, pat[3], 4'b0000, 1, 1);
    add(0, 1, 4'b0000, pat[1], 4'b0010, 1, 1);
    add(0, 1, 4'b0000, pat[1], 4'b0000, 1, 2);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 2);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 2);
    while (plan_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_vec++; if (leds_o !== e.leds) begin n_err++; $display("FAIL preempt step %0d: leds_o=%h expected %h", k, leds_o, e.leds); end
      n_vec++; if (ack_o !== e.ack) begin n_err++; $display("FAIL preempt step %0d: ack_o=%b expected %b", k, ack_o, e.ack); end
      n_vec++; if (busy_o !== e.busy) begin n_err++; $display("FAIL preempt step %0d: busy_o=%b expected %b", k, busy_o, e.busy); end
      k++;
    end
  endtask

  task automatic test_no_preempt();
    exp_t e;
    int   k = 0;
    add(0, 1, 4'b0010, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, pat[1], 4'b0010, 1, 1);
    add(0, 1, 4'b1000, pat[1], 4'b0000, 1, 1);
    add(0, 1, 4'b0000, pat[1], 4'b0000, 1, 1);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 2);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, pat[3], 4'b1000, 1, 1);
    add(0, 1, 4'b0000, pat[3], 4'b0000, 1, 2);
    add(0, 1, 4'b0001, 4'h0,   4'b0000, 1, 1);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 1);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, pat[0], 4'b0001, 1, 1);
    add(0, 1, 4'b0000, pat[0], 4'b0000, 1, 2);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 2);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 2);
    while (plan_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_vec++; if (leds_o !== e.leds) begin n_err++; $display("FAIL no_preempt step %0d: leds_o=%h expected %h", k, leds_o, e.leds); end
      n_vec++; if (ack_o !== e.ack) begin n_err++; $display("FAIL no_preempt step %0d: ack_o=%b expected %b", k, ack_o, e.ack); end
      n_vec++; if (busy_o !== e.busy) begin n_err++; $display("FAIL no_preempt step %0d: busy_o=%b expected %b", k, busy_o, e.busy); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   k = 0;
    add(0, 1, 4'b1111, BASE, 4'b0000, 0, 1);
    for (int r = 0; r < N_REQ; r++) begin
      add(0, 1, 4'b0000, pat[r], 4'(1 << r), 1, 1);
      add(0, 1, 4'b0000, pat[r], 4'b0000,    1, 2);
      add(0, 1, 4'b0000, 4'h0,   4'b0000,    1, 2);
      add(0, 1, 4'b0000, BASE,   4'b0000,    0, 1);
    end
    // Request held through its own grant cycle must not display twice.
    add(0, 1, 4'b0100, BASE,   4'b0000, 0, 1);
    add(0, 1, 4'b0100, pat[2], 4'b0100, 1, 1);
    add(0, 1, 4'b0000, pat[2], 4'b0000, 1, 2);
    add(0, 1, 4'b0000, 4'h0,   4'b0000, 1, 2);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 3);
    while (plan_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_vec++; if (leds_o !== e.leds) begin n_err++; $display("FAIL back_to_back step %0d: leds_o=%h expected %h", k, leds_o, e.leds); end
      n_vec++; if (ack_o !== e.ack) begin n_err++; $display("FAIL back_to_back step %0d: ack_o=%b expected %b", k, ack_o, e.ack); end
      n_vec++; if (busy_o !== e.busy) begin n_err++; $display("FAIL back_to_back step %0d: busy_o=%b expected %b", k, busy_o, e.busy); end
      k++;
    end
  endtask

  task automatic test_slow_tick_reset();
    exp_t e;
    int   k = 0;
    // Tick at cycles 5, 15, 25, ...: hold spans grant..24, gap 25..44.
    for (int c = 0; c < 50; c++) begin
      if (c == 0)      add(0, 0,             4'b0100, BASE,   4'b0000, 0, 1);
      else if (c == 1) add(0, 0,             4'b0000, pat[2], 4'b0100, 1, 1);
      else if (c < 25) add(0, (c % 10 == 5), 4'b0000, pat[2], 4'b0000, 1, 1);
      else if (c < 45) add(0, (c % 10 == 5), 4'b0000, 4'h0,   4'b0000, 1, 1);
      else             add(0, (c % 10 == 5), 4'b0000, BASE,   4'b0000, 0, 1);
    end
    // Reset while showing requester 2 with requester 3 queued.
    add(0, 0, 4'b0100, BASE,   4'b0000, 0, 1);
    add(0, 0, 4'b1000, pat[2], 4'b0100, 1, 1);
    add(0, 0, 4'b0000, pat[2], 4'b0000, 1, 1);
    add(1, 0, 4'b0000, 4'h0,   4'b0000, 0, 1);
    add(0, 1, 4'b0000, BASE,   4'b0000, 0, 6);
    while (plan_q.size() != 0) begin
      drive_next();
      e = exp_q.pop_front();
      n_vec++; if (leds_o !== e.leds) begin n_err++; $display("FAIL slow_reset step %0d: leds_o=%h expected %h", k, leds_o, e.leds); end
      n_vec++; if (ack_o !== e.ack) begin n_err++; $display("FAIL slow_reset step %0d: ack_o=%b expected %b", k, ack_o, e.ack); end
      n_vec++; if (busy_o !== e.busy) begin n_err++; $display("FAIL slow_reset step %0d: busy_o=%b expected %b", k, busy_o, e.busy); end
      k++;
    end
  endtask

  initial begin
    pat[0] = 4'h9;
    pat[1] = 4'h3;
    pat[2] = 4'h5;
    pat[3] = 4'hF;
    srst_i        = 1'b1;
    sample_tick_i = 1'b0;
    req_i         = '0;
    base_leds_i   = BASE;
    pattern_i     = {pat[3], pat[2], pat[1], pat[0]};

    test_reset();
    test_single_event();
    test_preempt();
    test_no_preempt();
    test_back_to_back();
    test_slow_tick_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
